// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the unified-RAM arbiter: bus widths, FSM
// state encoding, owner encoding and the grant/streak decision functions.
package ram_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_SERVE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

    localparam logic ARB_OWNER_IF  = 1'b0;
    localparam logic ARB_OWNER_MEM = 1'b1;

    // MEM normally has priority; IF takes the grant once MEM has won
    // `limit` times in a row while IF was kept waiting.
    function automatic logic mem_wins(input logic       if_req,
                                      input logic       mem_req,
                                      input logic [3:0] streak,
                                      input logic [3:0] limit);
        return mem_req & (~if_req | (streak != limit));
    endfunction

    // Streak only grows while MEM starves a waiting IF; any other grant clears it.
    function automatic logic [3:0] next_streak(input logic       mem_grant,
                                               input logic       if_req,
                                               input logic [3:0] streak);
        if (mem_grant && if_req) begin
            return streak + 4'd1;
        end else begin
            return 4'd0;
        end
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundles the IF requester, MEM requester and RAM bus signals of the arbiter.
// slave  : the arbiter's view.
// master : the environment's view (both requesters plus the RAM).
interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic                if_ack;
    logic [DATA_W-1:0]   if_rdata;

    logic                mem_req;
    logic [SEL_W-1:0]    mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_ack;
    logic [DATA_W-1:0]   mem_rdata;

    logic                bus_req;
    logic [SEL_W-1:0]    bus_we;
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wdata;
    logic [DATA_W-1:0]   bus_rdata;
    logic                bus_ready;
    logic                bus_timeout;

    logic                stall_if;
    logic                stall_mem;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ready,
        output bus_timeout,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ready,
        input  bus_timeout,
        input  stall_if, stall_mem
    );

endinterface

// File: rtl/ram_arbiter.sv
// Arbiter/sequencer for the single-port unified RAM shared by instruction
// fetch and the MEM stage. One access at a time: IDLE picks a requester and
// latches its request onto the bus, SERVE waits for ready or timeout, RESP
// returns a one-cycle registered ack with data to the owner.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned MEM_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  arb
);

    localparam logic [7:0] TIMEOUT_C      = 8'(TIMEOUT);
    localparam logic [3:0] STREAK_LIMIT_C = 4'(MEM_STREAK);

    arb_state_e         state_q,       state_d;
    logic               owner_q,       owner_d;
    logic [3:0]         streak_q,      streak_d;
    logic [7:0]         wait_q,        wait_d;
    logic               bus_req_q,     bus_req_d;
    logic [SEL_W-1:0]   bus_we_q,      bus_we_d;
    logic [ADDR_W-1:0]  bus_addr_q,    bus_addr_d;
    logic [DATA_W-1:0]  bus_wdata_q,   bus_wdata_d;
    logic               if_ack_q,      if_ack_d;
    logic               mem_ack_q,     mem_ack_d;
    logic [DATA_W-1:0]  if_rdata_q,    if_rdata_d;
    logic [DATA_W-1:0]  mem_rdata_q,   mem_rdata_d;
    logic               bus_timeout_q, bus_timeout_d;

    logic               grant_s;
    logic               mem_grant_s;
    logic               finish_s;
    logic [DATA_W-1:0]  rdata_s;

    // Next-state, bus latching, streak/wait counters and response generation.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        streak_d      = streak_q;
        wait_d        = wait_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        if_ack_d      = 1'b0;
        mem_ack_d     = 1'b0;
        if_rdata_d    = 32'h0;
        mem_rdata_d   = 32'h0;
        bus_timeout_d = 1'b0;
        finish_s      = 1'b0;
        rdata_s       = 32'h0;
        grant_s       = arb.if_req | arb.mem_req;
        mem_grant_s   = mem_wins(arb.if_req, arb.mem_req, streak_q, STREAK_LIMIT_C);

        case (state_q)
            ARB_IDLE: begin
                if (grant_s) begin
                    state_d   = ARB_SERVE;
                    bus_req_d = 1'b1;
                    wait_d    = 8'd0;
                    streak_d  = next_streak(mem_grant_s, arb.if_req, streak_q);
                    if (mem_grant_s) begin
                        owner_d     = ARB_OWNER_MEM;
                        bus_we_d    = arb.mem_we;
                        bus_addr_d  = arb.mem_addr;
                        bus_wdata_d = arb.mem_wdata;
                    end else begin
                        // Fetches are always reads.
                        owner_d     = ARB_OWNER_IF;
                        bus_we_d    = 4'b0000;
                        bus_addr_d  = arb.if_addr;
                        bus_wdata_d = 32'h0;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end

            ARB_SERVE: begin
                // Ready wins over a timeout landing in the same cycle.
                if (arb.bus_ready) begin
                    finish_s      = 1'b1;
                    bus_timeout_d = 1'b0;
                    if (bus_we_q != 4'b0000) begin
                        rdata_s = 32'h0;
                    end else begin
                        rdata_s = arb.bus_rdata;
                    end
                end else if ((wait_q + 8'd1) == TIMEOUT_C) begin
                    finish_s      = 1'b1;
                    bus_timeout_d = 1'b1;
                    rdata_s       = 32'h0;
                    wait_d        = wait_q + 8'd1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end

                if (finish_s) begin
                    state_d   = ARB_RESP;
                    bus_req_d = 1'b0;
                    if (owner_q == ARB_OWNER_MEM) begin
                        mem_ack_d   = 1'b1;
                        mem_rdata_d = rdata_s;
                    end else begin
                        if_ack_d    = 1'b1;
                        if_rdata_d  = rdata_s;
                    end
                end else begin
                    state_d = ARB_SERVE;
                end
            end

            ARB_RESP: begin
                state_d = ARB_IDLE;
            end

            default: begin
                state_d   = ARB_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            owner_q       <= ARB_OWNER_IF;
            streak_q      <= 4'd0;
            wait_q        <= 8'd0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 4'b0000;
            bus_addr_q    <= 32'h0;
            bus_wdata_q   <= 32'h0;
            if_ack_q      <= 1'b0;
            mem_ack_q     <= 1'b0;
            if_rdata_q    <= 32'h0;
            mem_rdata_q   <= 32'h0;
            bus_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            streak_q      <= streak_d;
            wait_q        <= wait_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            if_ack_q      <= if_ack_d;
            mem_ack_q     <= mem_ack_d;
            if_rdata_q    <= if_rdata_d;
            mem_rdata_q   <= mem_rdata_d;
            bus_timeout_q <= bus_timeout_d;
        end
    end

    assign arb.bus_req     = bus_req_q;
    assign arb.bus_we      = bus_we_q;
    assign arb.bus_addr    = bus_addr_q;
    assign arb.bus_wdata   = bus_wdata_q;
    assign arb.if_ack      = if_ack_q;
    assign arb.if_rdata    = if_rdata_q;
    assign arb.mem_ack     = mem_ack_q;
    assign arb.mem_rdata   = mem_rdata_q;
    assign arb.bus_timeout = bus_timeout_q;

    // Pipeline stalls are combinational so the stage releases in its ack cycle.
    assign arb.stall_if  = arb.if_req  & ~if_ack_q;
    assign arb.stall_mem = arb.mem_req & ~mem_ack_q;

endmodule
